parking_lot_ctrl: RTL and testbench



---
 rtl/parking_pkg.sv | 18 +
 rtl/parking_lot_ctrl_sensor_sync.sv | 31 +++
 rtl/parking_lot_ctrl.sv | 179 +++++++++++++++++
 tb/tb_parking_lot_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking lot occupancy controller.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENT_A,
    ENT_AB,
    ENT_B,
    EXT_B,
    EXT_AB,
    EXT_A,
    WAIT_CLR
  } lot_state_t;

  localparam int DEF_CAPACITY = 3;
  localparam int DEF_CNT_W    = 2;

endpackage

// File: rtl/parking_lot_ctrl_sensor_sync.sv
// Multi-flop synchronizer for one asynchronous sensor line.
module sensor_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/parking_lot_ctrl.sv
// Direction-decoding FSM and saturating occupancy counter for a small lot;
// cars feeds the spot/FULL display decoder directly.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sensor_a,
  input  logic             sensor_b,
  output logic [CNT_W-1:0] cars,
  output logic             full,
  output logic             enter_p,
  output logic             exit_p,
  output logic             reject_p,
  output logic             underflow_p
);

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  logic       a_s, b_s;
  logic [1:0] ab;

  lot_state_t       state_q, state_d;
  logic [CNT_W-1:0] cars_q, cars_d;
  logic             full_q, full_d;
  logic             enter_q, enter_d;
  logic             exit_q, exit_d;
  logic             reject_q, reject_d;
  logic             underflow_q, underflow_d;
  logic             enter_ev, exit_ev;

  sensor_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sensor_a),
    .q       (a_s)
  );

  sensor_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sensor_b),
    .q       (b_s)
  );

  assign ab = {a_s, b_s};

  // Exit states mirror the entry states with the roles of A and B swapped.
  always_comb begin
    state_d  = state_q;
    enter_ev = 1'b0;
    exit_ev  = 1'b0;
    case (state_q)
      IDLE: begin
        case (ab)
          2'b10:   state_d = ENT_A;
          2'b01:   state_d = EXT_B;
          2'b11:   state_d = WAIT_CLR;
          default: state_d = IDLE;
        endcase
      end
      ENT_A: begin
        case (ab)
          2'b11:   state_d = ENT_AB;
          2'b00:   state_d = IDLE;
          2'b01:   state_d = WAIT_CLR;
          default: state_d = ENT_A;
        endcase
      end
      ENT_AB: begin
        case (ab)
          2'b01:   state_d = ENT_B;
          2'b10:   state_d = ENT_A;
          2'b00:   state_d = IDLE;
          default: state_d = ENT_AB;
        endcase
      end
      ENT_B: begin
        case (ab)
          2'b00: begin
            state_d  = IDLE;
            enter_ev = 1'b1;
          end
          2'b11:   state_d = ENT_AB;
          2'b10:   state_d = WAIT_CLR;
          default: state_d = ENT_B;
        endcase
      end
      EXT_B: begin
        case (ab)
          2'b11:   state_d = EXT_AB;
          2'b00:   state_d = IDLE;
          2'b10:   state_d = WAIT_CLR;
          default: state_d = EXT_B;
        endcase
      end
      EXT_AB: begin
        case (ab)
          2'b10:   state_d = EXT_A;
          2'b01:   state_d = EXT_B;
          2'b00:   state_d = IDLE;
          default: state_d = EXT_AB;
        endcase
      end
      EXT_A: begin
        case (ab)
          2'b00: begin
            state_d = IDLE;
            exit_ev = 1'b1;
          end
          2'b11:   state_d = EXT_AB;
          2'b01:   state_d = WAIT_CLR;
          default: state_d = EXT_A;
        endcase
      end
      WAIT_CLR: begin
        if (ab == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Count clamps at both ends; a blocked event raises its own strobe instead.
  always_comb begin
    cars_d      = cars_q;
    enter_d     = 1'b0;
    exit_d      = 1'b0;
    reject_d    = 1'b0;
    underflow_d = 1'b0;
    if (enter_ev) begin
      if (cars_q < CAP_C) begin
        cars_d  = cars_q + CNT_W'(1);
        enter_d = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end else if (exit_ev) begin
      if (cars_q != '0) begin
        cars_d = cars_q - CNT_W'(1);
        exit_d = 1'b1;
      end else begin
        underflow_d = 1'b1;
      end
    end
    full_d = (cars_d == CAP_C);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cars_q      <= '0;
      full_q      <= 1'b0;
      enter_q     <= 1'b0;
      exit_q      <= 1'b0;
      reject_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cars_q      <= cars_d;
      full_q      <= full_d;
      enter_q     <= enter_d;
      exit_q      <= exit_d;
      reject_q    <= reject_d;
      underflow_q <= underflow_d;
    end
  end

  assign cars        = cars_q;
  assign full        = full_q;
  assign enter_p     = enter_q;
  assign exit_p      = exit_q;
  assign reject_p    = reject_q;
  assign underflow_p = underflow_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl: entry/exit decoding, saturation and reset.
module tb_parking_lot_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sensor_a = 1'b0;
  logic       sensor_b = 1'b0;
  logic [1:0] cars;
  logic       full, enter_p, exit_p, reject_p, underflow_p;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_enter = 0, n_exit = 0, n_reject = 0, n_under = 0;
  int last_strobe_cyc = 0;
  int width_err = 0;
  logic prev_en = 1'b0, prev_ex = 1'b0, prev_rj = 1'b0, prev_un = 1'b0;

  parking_lot_ctrl #(.CAPACITY(3), .CNT_W(2), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sensor_a    (sensor_a),
    .sensor_b    (sensor_b),
    .cars        (cars),
    .full        (full),
    .enter_p     (enter_p),
    .exit_p      (exit_p),
    .reject_p    (reject_p),
    .underflow_p (underflow_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (enter_p) n_enter <= n_enter + 1;
    if (exit_p) n_exit <= n_exit + 1;
    if (reject_p) n_reject <= n_reject + 1;
    if (underflow_p) n_under <= n_under + 1;
    if (enter_p || exit_p || reject_p || underflow_p) last_strobe_cyc <= cyc;
    if ((enter_p && prev_en) || (exit_p && prev_ex) ||
        (reject_p && prev_rj) || (underflow_p && prev_un))
      width_err <= width_err + 1;
    prev_en <= enter_p;
    prev_ex <= exit_p;
    prev_rj <= reject_p;
    prev_un <= underflow_p;
  end

  task automatic drive(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic entry_seq();
    drive(1'b1, 1'b0, 4);
    drive(1'b1, 1'b1, 4);
    drive(1'b0, 1'b1, 4);
    drive(1'b0, 1'b0, 4);
  endtask

  task automatic exit_seq();
    drive(1'b0, 1'b1, 4);
    drive(1'b1, 1'b1, 4);
    drive(1'b1, 1'b0, 4);
    drive(1'b0, 1'b0, 4);
  endtask

  task automatic test_reset();
    int e0, x0, r0, u0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cars !== 2'd0) begin
      errors++;
      $display("FAIL reset_cars: got %0d expected 0", cars);
    end
    checks++;
    if ({full, enter_p, exit_p, reject_p, underflow_p} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {full, enter_p, exit_p, reject_p, underflow_p});
    end
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 4);
    drive(1'b1, 1'b1, 4);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cars, full} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_seq: got cars=%0d full=%b expected 0/0", cars, full);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    e0 = n_enter; x0 = n_exit; r0 = n_reject; u0 = n_under;
    drive(1'b0, 1'b1, 4);
    drive(1'b0, 1'b0, 4);
    checks++;
    if ((n_enter - e0) + (n_exit - x0) + (n_reject - r0) + (n_under - u0) != 0) begin
      errors++;
      $display("FAIL reset_discard_strobes: got %0d expected 0",
               (n_enter - e0) + (n_exit - x0) + (n_reject - r0) + (n_under - u0));
    end
    checks++;
    if (cars !== 2'd0) begin
      errors++;
      $display("FAIL reset_discard_cars: got %0d expected 0", cars);
    end
  endtask

  task automatic test_clean_entry();
    int e0, c0;
    e0 = n_enter;
    drive(1'b1, 1'b0, 4);
    drive(1'b1, 1'b1, 4);
    drive(1'b0, 1'b1, 4);
    c0 = cyc;
    drive(1'b0, 1'b0, 4);
    checks++;
    if (n_enter - e0 != 1) begin
      errors++;
      $display("FAIL entry_pulse_count: got %0d expected 1", n_enter - e0);
    end
    checks++;
    if (last_strobe_cyc - c0 != 3) begin
      errors++;
      $display("FAIL entry_latency: got %0d expected 3", last_strobe_cyc - c0);
    end
    checks++;
    if (cars !== 2'd1 || full !== 1'b0) begin
      errors++;
      $display("FAIL entry_cars: got cars=%0d full=%b expected 1/0", cars, full);
    end
  endtask

  task automatic test_fill();
    int e0, r0;
    logic [1:0] exp_cars[3] = '{2'd2, 2'd3, 2'd3};
    logic       exp_full[3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      e0 = n_enter;
      r0 = n_reject;
      entry_seq();
      checks++;
      if (cars !== exp_cars[i] || full !== exp_full[i]) begin
        errors++;
        $display("FAIL fill_%0d: got cars=%0d full=%b expected %0d/%b",
                 i, cars, full, exp_cars[i], exp_full[i]);
      end
      checks++;
      if ((n_enter - e0) != (i < 2 ? 1 : 0) || (n_reject - r0) != (i < 2 ? 0 : 1)) begin
        errors++;
        $display("FAIL fill_strobe_%0d: got enter=%0d reject=%0d expected %0d/%0d",
                 i, n_enter - e0, n_reject - r0, (i < 2 ? 1 : 0), (i < 2 ? 0 : 1));
      end
    end
  endtask

  task automatic test_exits();
    int x0, u0;
    x0 = n_exit;
    exit_seq();
    checks++;
    if (cars !== 2'd2 || full !== 1'b0 || n_exit - x0 != 1) begin
      errors++;
      $display("FAIL exit_from_full: got cars=%0d full=%b exits=%0d expected 2/0/1",
               cars, full, n_exit - x0);
    end
    exit_seq();
    checks++;
    if (cars !== 2'd1) begin
      errors++;
      $display("FAIL exit_to_one: got %0d expected 1", cars);
    end
    for (int i = 0; i < 4; i++) begin
      x0 = n_exit;
      u0 = n_under;
      exit_seq();
      checks++;
      if (cars !== 2'd0) begin
        errors++;
        $display("FAIL underflow_cars_%0d: got %0d expected 0", i, cars);
      end
      checks++;
      if ((n_exit - x0) != (i == 0 ? 1 : 0) || (n_under - u0) != (i == 0 ? 0 : 1)) begin
        errors++;
        $display("FAIL underflow_strobe_%0d: got exit=%0d under=%0d expected %0d/%0d",
                 i, n_exit - x0, n_under - u0, (i == 0 ? 1 : 0), (i == 0 ? 0 : 1));
      end
    end
  endtask

  task automatic test_back_out();
    int tot0;
    tot0 = n_enter + n_exit + n_reject + n_under;
    drive(1'b1, 1'b0, 4);
    drive(1'b1, 1'b1, 4);
    drive(1'b1, 1'b0, 4);
    drive(1'b0, 1'b0, 4);
    checks++;
    if (n_enter + n_exit + n_reject + n_under - tot0 != 0 || cars !== 2'd0) begin
      errors++;
      $display("FAIL back_out: got strobes=%0d cars=%0d expected 0/0",
               n_enter + n_exit + n_reject + n_under - tot0, cars);
    end
  endtask

  task automatic test_illegal();
    int tot0, e0;
    tot0 = n_enter + n_exit + n_reject + n_under;
    drive(1'b1, 1'b0, 4);
    drive(1'b0, 1'b1, 4);
    drive(1'b1, 1'b1, 4);
    drive(1'b1, 1'b0, 4);
    drive(1'b0, 1'b0, 4);
    checks++;
    if (n_enter + n_exit + n_reject + n_under - tot0 != 0) begin
      errors++;
      $display("FAIL illegal_no_event: got %0d expected 0",
               n_enter + n_exit + n_reject + n_under - tot0);
    end
    e0 = n_enter;
    entry_seq();
    checks++;
    if (n_enter - e0 != 1 || cars !== 2'd1) begin
      errors++;
      $display("FAIL illegal_recover: got enters=%0d cars=%0d expected 1/1",
               n_enter - e0, cars);
    end
  endtask

  task automatic test_async_reset();
    entry_seq();
    checks++;
    if (cars !== 2'd2) begin
      errors++;
      $display("FAIL async_setup: got %0d expected 2", cars);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (cars !== 2'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got cars=%0d full=%b expected 0/0", cars, full);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_strobe_width();
    checks++;
    if (width_err != 0) begin
      errors++;
      $display("FAIL strobe_width: got %0d wide strobes expected 0", width_err);
    end
  endtask

  initial begin
    test_reset();
    test_clean_entry();
    test_fill();
    test_exits();
    test_back_out();
    test_illegal();
    test_async_reset();
    test_strobe_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
